// File: rtl/ffo_pkg.sv
// Shared types and constants for the find-first-one engine and its inverse decoder.
package ffo_pkg;

    localparam int FFO_WIDTH = 32;
    localparam int FFO_POS_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ffo_state_e;

    typedef logic [FFO_POS_W-1:0] ffo_pos_t;

endpackage

// File: rtl/ffo_down_counter.sv
// Loadable down-counter with zero flag; it saturates at zero instead of wrapping.
module ffo_down_counter
    import ffo_pkg::*;
#(
    parameter int W = FFO_POS_W
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         zero
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (dec && (q != '0)) begin
            q <= q - 1'b1;
        end
    end

    assign zero = (q == '0);

endmodule

// File: rtl/ffo_decode32s.sv
// Sequential position-to-one-hot decoder: walks a single 1 from b[0] to b[p] over p+1 cycles.
// Optional thermometer output is enabled with the FFO_DECODE_MASK_EN macro.
module ffo_decode32s
    import ffo_pkg::*;
#(
    parameter int WIDTH = FFO_WIDTH,
    localparam int POS_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [POS_W-1:0] p,
    output logic [0:WIDTH-1] b,
    output logic             ready,
    output logic             done
`ifdef FFO_DECODE_MASK_EN
    ,
    output logic [0:WIDTH-1] mask
`endif
);

    // Internal bit WIDTH-1 is the externally visible index 0.
    localparam logic [WIDTH-1:0] MSB_ONE = {1'b1, {(WIDTH-1){1'b0}}};

    ffo_state_e       state_q;
    ffo_state_e       state_d;
    logic [WIDTH-1:0] sr_q;
    logic [POS_W-1:0] cnt;
    logic             cnt_zero;
    logic             accept;
    logic             shift_en;
    logic             finish;

    assign accept   = (state_q == IDLE) && start;
    assign shift_en = (state_q == SHIFT) && !cnt_zero;
    assign finish   = (state_q == SHIFT) && cnt_zero;

    ffo_down_counter #(
        .W (POS_W)
    ) u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (accept),
        .dec   (shift_en),
        .d     (p),
        .q     (cnt),
        .zero  (cnt_zero)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = SHIFT;
            SHIFT:   if (cnt_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_q <= '0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                sr_q <= MSB_ONE;
            end else if (shift_en) begin
                sr_q <= sr_q >> 1;
            end
        end
    end

    assign b = sr_q;

`ifdef FFO_DECODE_MASK_EN
    logic [WIDTH-1:0] mask_q;

    // Thermometer fills behind the walking 1, so it covers indices 0..p at done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (accept) begin
            mask_q <= MSB_ONE;
        end else if (shift_en) begin
            mask_q <= (mask_q >> 1) | MSB_ONE;
        end
    end

    assign mask = mask_q;
`endif

endmodule

// File: tb/tb_ffo_decode32s.sv
// Self-checking bench for ffo_decode32s with a behavioural position/one-hot reference model.
module tb_ffo_decode32s;

    logic        clock;
    logic        reset;
    logic        start;
    logic [4:0]  p;
    logic [0:31] b;
    logic        ready;
    logic        done;
`ifdef FFO_DECODE_MASK_EN
    logic [0:31] mask;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    ffo_decode32s dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .p     (p),
        .b     (b),
        .ready (ready),
        .done  (done)
`ifdef FFO_DECODE_MASK_EN
        ,
        .mask  (mask)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: one-hot at position k, thermometer 0..k, and first-one search.
    function automatic logic [0:31] onehot(input int k);
        logic [0:31] r;
        r = '0;
        r[k] = 1'b1;
        return r;
    endfunction

    function automatic logic [0:31] thermo(input int k);
        logic [0:31] r;
        r = '0;
        for (int i = 0; i <= k; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic int ffo(input logic [0:31] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Issues one request from idle and counts busy cycles until ready returns.
    task automatic run_decode(input int pp, output int low, output bit done_ok);
        @(negedge clock);
        start = 1'b1;
        p     = 5'(pp);
        @(negedge clock);
        start = 1'b0;
        p     = 5'($urandom);
        low     = 0;
        done_ok = 1'b1;
        while (!ready && low < 100) begin
            if (done) done_ok = 1'b0;
            low++;
            @(negedge clock);
        end
        if (!done) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        start = 1'b0;
        p     = '0;
        repeat (2) @(negedge clock);
        total_cnt++;
        if ({b, ready, done} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL reset_hold: b=%h ready=%b done=%b want b=0 ready=1 done=0", b, ready, done);
        else pass_cnt++;
        reset = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clock);
            if ({b, ready, done} !== {32'h0, 1'b1, 1'b0}) bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL reset_idle: outputs changed while idle, b=%h ready=%b done=%b", b, ready, done);
        else pass_cnt++;
    endtask

    task automatic test_p0();
        int low;
        bit dok;
        run_decode(0, low, dok);
        total_cnt++;
        if (low !== 1) $display("FAIL p0_latency: got %0d want 1", low);
        else pass_cnt++;
        total_cnt++;
        if (b !== 32'h8000_0000 || !dok) $display("FAIL p0_result: b=%h done_ok=%b want 80000000 1", b, dok);
        else pass_cnt++;
    endtask

    task automatic test_p31();
        int low;
        bit dok;
        run_decode(31, low, dok);
        total_cnt++;
        if (low !== 32) $display("FAIL p31_latency: got %0d want 32", low);
        else pass_cnt++;
        total_cnt++;
        if (b !== 32'h0000_0001 || !dok) $display("FAIL p31_result: b=%h done_ok=%b want 00000001 1", b, dok);
        else pass_cnt++;
`ifdef FFO_DECODE_MASK_EN
        total_cnt++;
        if (mask !== 32'hFFFF_FFFF) $display("FAIL p31_mask: got %h want ffffffff", mask);
        else pass_cnt++;
`endif
    endtask

    task automatic test_ignore_start();
        int low;
        bit dok;
        @(negedge clock);
        start = 1'b1;
        p     = 5'd5;
        @(negedge clock);
        start = 1'b0;
        low = 0;
        dok = 1'b1;
        while (!ready && low < 100) begin
            if (done) dok = 1'b0;
            low++;
            if (low == 2) begin
                start = 1'b1;
                p     = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
        end
        if (!done) dok = 1'b0;
        start = 1'b0;
        total_cnt++;
        if (low !== 6) $display("FAIL ignore_latency: got %0d want 6", low);
        else pass_cnt++;
        total_cnt++;
        if (b !== onehot(5) || !dok) $display("FAIL ignore_result: b=%h done_ok=%b want %h 1", b, dok, onehot(5));
        else pass_cnt++;
`ifdef FFO_DECODE_MASK_EN
        total_cnt++;
        if (mask !== 32'hFC00_0000) $display("FAIL ignore_mask: got %h want fc000000", mask);
        else pass_cnt++;
`endif
        @(negedge clock);
        total_cnt++;
        if (ready !== 1'b1 || done !== 1'b0) $display("FAIL ignore_requeue: ready=%b done=%b want 1 0", ready, done);
        else pass_cnt++;
    endtask

    task automatic test_reset_abort();
        int low;
        bit dok;
        bit bad;
        @(negedge clock);
        start = 1'b1;
        p     = 5'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (6) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if ({b, ready, done} !== {32'h0, 1'b1, 1'b0})
            $display("FAIL abort_async: b=%h ready=%b done=%b want b=0 ready=1 done=0", b, ready, done);
        else pass_cnt++;
        @(negedge clock);
        reset = 1'b0;
        bad = 1'b0;
        repeat (25) begin
            @(negedge clock);
            if (done !== 1'b0 || ready !== 1'b1) bad = 1'b1;
        end
        total_cnt++;
        if (bad) $display("FAIL abort_no_done: ready=%b done=%b want 1 0 after abort", ready, done);
        else pass_cnt++;
        run_decode(3, low, dok);
        total_cnt++;
        if (low !== 4 || b !== onehot(3) || !dok)
            $display("FAIL abort_then_p3: low=%0d b=%h done_ok=%b want 4 %h 1", low, b, dok, onehot(3));
        else pass_cnt++;
    endtask

    task automatic test_random();
        int low;
        bit dok;
        int k;
        repeat (12) begin
            k = int'($urandom_range(0, 31));
            run_decode(k, low, dok);
            total_cnt++;
            if (low !== k + 1 || b !== onehot(k) || !dok)
                $display("FAIL random_p%0d: low=%0d b=%h done_ok=%b want %0d %h 1", k, low, b, dok, k + 1, onehot(k));
            else pass_cnt++;
`ifdef FFO_DECODE_MASK_EN
            total_cnt++;
            if (mask !== thermo(k)) $display("FAIL random_mask_p%0d: got %h want %h", k, mask, thermo(k));
            else pass_cnt++;
`endif
        end
    endtask

    task automatic test_back_to_back();
        int order[$];
        int idx;
        int cur;
        int low;
        int checked;
        int n;
        for (int i = 0; i < 32; i++) order.push_back(i);
        repeat (16) order.push_back(int'($urandom_range(0, 31)));
        n = order.size();
        idx = 0;
        cur = -1;
        low = 0;
        checked = 0;
        @(negedge clock);
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && checked < n; cyc++) begin
            if (ready) begin
                if (cur >= 0) begin
                    total_cnt++;
                    if (done !== 1'b1 || ffo(b) !== order[cur] || b !== onehot(order[cur]) ||
                        low !== order[cur] + 1)
                        $display("FAIL roundtrip_%0d: done=%b ffo=%0d low=%0d want 1 %0d %0d",
                                 cur, done, ffo(b), low, order[cur], order[cur] + 1);
                    else pass_cnt++;
                    checked++;
                end
                if (idx < n) begin
                    p   = 5'(order[idx]);
                    cur = idx;
                    idx++;
                    low = 0;
                end else begin
                    start = 1'b0;
                    cur   = -1;
                end
            end else begin
                low++;
            end
            @(negedge clock);
        end
        start = 1'b0;
        total_cnt++;
        if (checked !== n) $display("FAIL roundtrip_count: got %0d want %0d", checked, n);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_p0();
        test_p31();
        test_ignore_start();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
